pio_button_ctrl: RTL and testbench

//  Avalon-MM slave controller for the push-button PIO. Adds to the raw button input:
//  - 2-flop synchronisation and optional per-bit debounce
//  - edge capture and per-bit interrupt masking

---
 rtl/pio_button_ctrl.sv | 159 +++++++++++++++
 tb/tb_pio_button_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_button_ctrl.sv
// pio_button_ctrl: Avalon-MM push-button PIO controller.
// Raw pins are synchronised through two flops and optionally debounced. The
// controller latches configured edges and raises one masked level interrupt.
// Optional feature macro: PIO_BUTTON_DEBOUNCE_EN adds a per-bit debounce
// counter. Without it, the stable level follows the synchronised pins directly.
// Register map (word address):
//   0 DATA      RO      debounced level
//   1 IRQ_MASK  RW      per-bit interrupt enable
//   2 EDGE_CAP  RO/W1C  latched edges
//   3 EDGE_CFG  RW      bit0 = capture rising, bit1 = capture falling
module pio_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [1:0]       r_edge_cfg;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_data;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  // Upper write-data bits are deliberately discarded.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous button pins; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_BUTTON_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [WIDTH];

  // Per-bit debounce: accept a new level only after it has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end
`else
  // Without debounce the stable level simply follows the synchronised pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '1;
    end else begin
      r_stable <= r_sync2;
    end
  end
`endif

  assign w_rise = r_stable & ~r_stable_d;
  assign w_fall = ~r_stable & r_stable_d;
  assign w_set  = (w_rise & {WIDTH{r_edge_cfg[0]}}) | (w_fall & {WIDTH{r_edge_cfg[1]}});

  // W1C clear mask for EDGE_CAP; a simultaneous capture takes priority.
  always_comb begin
    w_clr = '0;
    if (w_wr && (address == 2'd2)) begin
      w_clr = w_wdata;
    end else begin
      w_clr = '0;
    end
  end

  // Edge history, edge capture and the software-writable control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '1;
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_edge_cfg <= 2'b10;
    end else begin
      r_stable_d <= r_stable;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
      if (w_wr && (address == 2'd1)) begin
        r_irq_mask <= w_wdata;
      end
      if (w_wr && (address == 2'd3)) begin
        r_edge_cfg <= writedata[1:0];
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    w_rd_data = 32'h0;
    case (address)
      2'd0:    w_rd_data[WIDTH-1:0] = r_stable;
      2'd1:    w_rd_data[WIDTH-1:0] = r_irq_mask;
      2'd2:    w_rd_data[WIDTH-1:0] = r_edge_cap;
      2'd3:    w_rd_data[1:0]       = r_edge_cfg;
      default: w_rd_data            = 32'h0;
    endcase
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'h0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_data;
      r_irq      <= |(r_edge_cap & r_irq_mask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_button_ctrl.sv
// tb_pio_button_ctrl: directed bench for pio_button_ctrl (WIDTH=4,
// DEBOUNCE_CYCLES=4). A history-window model predicts readdata and irq every
// cycle; directed literal checks pin the model's timing and values.
module tb_pio_button_ctrl;

`ifdef PIO_BUTTON_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  // Negedge count from a pin change to DATA showing the new level.
  localparam int EXP_LAT = 2 + DB + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  pio_button_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_ph[k] holds the pin value sampled k+1 edges ago. A bit's level is
  // accepted once the last DB synchronised samples all agree and differ.
  logic [7:0][3:0] m_ph;
  logic [3:0]  m_stable, m_stable_d, m_cap, m_mask;
  logic [1:0]  m_cfg;
  logic [31:0] m_rd;
  logic        m_irq;

  function automatic logic [3:0] accept(input logic [7:0][3:0] ph, input logic [3:0] st);
    logic [3:0] res;
    logic       same;
    res = st;
    for (int b = 0; b < 4; b++) begin
      same = 1'b1;
      for (int k = 1; k <= DB; k++) begin
        if (ph[k][b] != ph[1][b]) same = 1'b0;
      end
      if (same && (ph[1][b] != st[b])) res[b] = ph[1][b];
    end
    return res;
  endfunction

  function automatic logic [31:0] view(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_stable};
      2'd1:    return {28'h0, m_mask};
      2'd2:    return {28'h0, m_cap};
      default: return {30'h0, m_cfg};
    endcase
  endfunction

  function automatic logic [3:0] new_edges();
    logic [3:0] e;
    e = 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (m_stable[b] && !m_stable_d[b] && m_cfg[0]) e[b] = 1'b1;
      if (!m_stable[b] && m_stable_d[b] && m_cfg[1]) e[b] = 1'b1;
    end
    return e;
  endfunction

  wire       m_wr = chipselect && !write_n;
  wire [3:0] m_clr = (m_wr && address == 2'd2) ? writedata[3:0] : 4'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= '1; m_stable <= 4'hF; m_stable_d <= 4'hF; m_cap <= 4'h0;
      m_mask <= 4'h0; m_cfg <= 2'b10; m_rd <= 32'h0; m_irq <= 1'b0;
    end else begin
      m_ph       <= {m_ph[6:0], in_port};
      m_stable   <= accept(m_ph, m_stable);
      m_stable_d <= m_stable;
      m_cap      <= (m_cap & ~m_clr) | new_edges();
      if (m_wr && address == 2'd1) m_mask <= writedata[3:0];
      if (m_wr && address == 2'd3) m_cfg <= writedata[1:0];
      m_rd  <= view(address);
      m_irq <= |(m_cap & m_mask);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_readdata", readdata, m_rd);
    check("model_irq", {31'h0, irq}, {31'h0, m_irq});
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    address = a;
    @(negedge clk);
    check(nm, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;

    // 1: reset with pins idle high
    #1 reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(1);
    rd(2'd0, 32'hF, "reset_data");
    rd(2'd1, 32'h0, "reset_mask");
    rd(2'd2, 32'h0, "reset_cap");
    rd(2'd3, 32'h2, "reset_cfg");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_irq_quiet", {31'h0, irq}, 32'h0);
    end

    // 2: debounce accept on bit 0
    wr(2'd1, 32'h1);
    address = 2'd0;
    in_port = 4'hE;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lat == 0 && readdata == 32'hE) lat = c;
    end
    check("accept_latency", lat, EXP_LAT);
    rd(2'd2, 32'h1, "accept_cap");
    check("accept_irq", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    in_port = 4'hF;
    idle(12);
    check("accept_irq_cleared", {31'h0, irq}, 32'h0);

    // 3: three-cycle glitch on bit 1
    in_port = 4'hD;
    idle(3);
    in_port = 4'hF;
    idle(12);
`ifdef PIO_BUTTON_DEBOUNCE_EN
    rd(2'd0, 32'hF, "glitch_data");
    rd(2'd2, 32'h0, "glitch_cap");
    check("glitch_irq", {31'h0, irq}, 32'h0);
`endif

    // 4: W1C with two captured bits
    wr(2'd2, 32'hF);
    wr(2'd1, 32'h3);
    in_port = 4'hC;
    idle(12);
    in_port = 4'hF;
    idle(12);
    rd(2'd2, 32'h3, "w1c_before");
    check("w1c_irq_before", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h2, "w1c_bit0");
    check("w1c_irq_held", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h2);
    check("w1c_irq_lag", {31'h0, irq}, 32'h1);
    rd(2'd2, 32'h0, "w1c_bit1");
    check("w1c_irq_drop", {31'h0, irq}, 32'h0);

    // 5: clear of bit 2 in the very cycle its falling edge is captured
    in_port = 4'hB;
    idle(EXP_LAT - 1);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h4, "set_beats_clear");
    wr(2'd2, 32'h4);
    in_port = 4'hF;
    idle(12);
    rd(2'd2, 32'h0, "set_clear_cleanup");

    // 6: rising-only capture on bit 3
    wr(2'd3, 32'h1);
    address = 2'd2;
    in_port = 4'h7;
    idle(12);
    check("rise_press_ignored", readdata, 32'h0);
    in_port = 4'hF;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lat == 0 && readdata != 32'h0) lat = c;
    end
    check("rise_cap_latency", lat, EXP_LAT + 1);
    check("rise_cap_value", readdata, 32'h8);

    // 7: asynchronous reset in the middle of a debounce
    wr(2'd1, 32'hF);
    address = 2'd3;
    idle(2);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    check("pre_reset_rd", readdata, 32'h1);
    in_port = 4'h0;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_rd", readdata, 32'h0);
    check("async_reset_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hF;
    idle(2);
    reset_n = 1'b1;
    rd(2'd0, 32'hF, "post_reset_data");
    rd(2'd3, 32'h2, "post_reset_cfg");
    rd(2'd1, 32'h0, "post_reset_mask");
    rd(2'd2, 32'h0, "post_reset_cap");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
